// File: rtl/hub75_rx_pkg.sv
// Shared definitions for the HUB75 receiver: FSM encoding, field widths,
// error flag positions and the plane-advance rule applied at each latch.
package hub75_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } rx_state_e;

  localparam int ROW_W   = 5;
  localparam int COL_W   = 6;
  localparam int LEN_W   = 7;
  localparam int PLANE_W = 2;
  localparam int RGB_W   = 3;
  localparam int ADDR_W  = ROW_W + COL_W;
  localparam int DATA_W  = 2 * RGB_W;
  localparam int ERR_W   = 2;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_LENGTH   = 1;

  localparam logic [ROW_W-1:0]   LAST_ROW   = '1;
  localparam logic [PLANE_W-1:0] LAST_PLANE = '1;

  // Re-latching the same row advances the PWM plane; a new row restarts at plane 0.
  function automatic logic [PLANE_W-1:0] nextPlane(
    input logic [ROW_W-1:0]   newRow,
    input logic [ROW_W-1:0]   curRow,
    input logic [PLANE_W-1:0] curPlane
  );
    if (newRow == curRow) begin
      return curPlane + 1'b1;
    end
    return '0;
  endfunction

endpackage

// File: rtl/hub75_sync_edge.sv
// One synchronizer chain for an asynchronous panel strobe, followed by a
// registered rising/falling edge detector. The edge outputs lag the last
// synchronizer stage by one register, so companion data must be delayed by
// one extra register after its own chain to stay aligned with the edge.
module hub75_sync_edge
  import hub75_rx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;

  // Shift the pin through the chain and register edges against the delayed copy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chain_q <= '0;
      dly_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
      dly_q  <= chain_q[STAGES-1];
      rise_q <= chain_q[STAGES-1] & ~dly_q;
      fall_q <= ~chain_q[STAGES-1] & dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel receiver: synchronizes the panel bus into the system clock,
// turns each shift clock into a framebuffer write and each latch into a
// line-complete event carrying row, PWM plane and error status.
module hub75_rx
  import hub75_rx_pkg::*;
#(
  parameter int COLS        = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LP_CLK,
  input  logic               LATCH,
  input  logic [ROW_W-1:0]   ROW,
  input  logic [RGB_W-1:0]   RGB0,
  input  logic [RGB_W-1:0]   RGB1,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [PLANE_W-1:0] wr_plane,
  output logic               line_done,
  output logic [LEN_W-1:0]   line_len,
  output logic               frame_done,
  output logic [ERR_W-1:0]   err
);

  localparam int BUS_W = ROW_W + DATA_W;
  localparam logic [LEN_W-1:0] COLS_L = LEN_W'(COLS);

  logic lpRise;
  logic latchRise;
  logic latchFall;

  logic [BUS_W-1:0] busPin;
  logic [BUS_W-1:0] busSync_q [SYNC_STAGES];
  logic [BUS_W-1:0] busAl_q;
  logic [ROW_W-1:0] rowAl;
  logic [DATA_W-1:0] rgbAl;

  rx_state_e           state_q;
  logic [LEN_W-1:0]    colCnt_q;
  logic [LEN_W-1:0]    colCnt_d;
  logic [ROW_W-1:0]    rowCur_q;
  logic [PLANE_W-1:0]  planeCur_q;
  logic [PLANE_W-1:0]  planeCur_d;
  logic                writeHit;
  logic                overflowHit;

  logic                wrEn_q;
  logic [ADDR_W-1:0]   wrAddr_q;
  logic [DATA_W-1:0]   wrData_q;
  logic [PLANE_W-1:0]  wrPlane_q;
  logic                lineDone_q;
  logic [LEN_W-1:0]    lineLen_q;
  logic                frameDone_q;
  logic [ERR_W-1:0]    err_q;

  hub75_sync_edge #(.STAGES(SYNC_STAGES)) uLpClkSync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (LP_CLK),
    .rise_o (lpRise),
    .fall_o ()
  );

  hub75_sync_edge #(.STAGES(SYNC_STAGES)) uLatchSync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (LATCH),
    .rise_o (latchRise),
    .fall_o (latchFall)
  );

  assign busPin = {ROW, RGB0, RGB1};

  // Row and pixel bits take the same chain length plus one alignment register as the edge path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        busSync_q[i] <= '0;
      end
      busAl_q <= '0;
    end else begin
      busSync_q[0] <= busPin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        busSync_q[i] <= busSync_q[i-1];
      end
      busAl_q <= busSync_q[SYNC_STAGES-1];
    end
  end

  assign rowAl = busAl_q[BUS_W-1 -: ROW_W];
  assign rgbAl = busAl_q[DATA_W-1:0];

  // Resolve this cycle's shift edge first so a coinciding latch sees the updated column count.
  always_comb begin
    writeHit    = 1'b0;
    overflowHit = 1'b0;
    colCnt_d    = colCnt_q;
    if ((state_q == ST_SHIFT) && lpRise) begin
      if (colCnt_q < COLS_L) begin
        writeHit = 1'b1;
        colCnt_d = colCnt_q + 1'b1;
      end else begin
        overflowHit = 1'b1;
      end
    end
    planeCur_d = nextPlane(rowAl, rowCur_q, planeCur_q);
  end

  // Line FSM with registered write, line and frame outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      colCnt_q    <= '0;
      rowCur_q    <= '0;
      planeCur_q  <= '0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      wrPlane_q   <= '0;
      lineDone_q  <= 1'b0;
      lineLen_q   <= '0;
      frameDone_q <= 1'b0;
      err_q       <= '0;
    end else begin
      wrEn_q      <= 1'b0;
      lineDone_q  <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (latchFall) begin
            state_q  <= ST_SHIFT;
            colCnt_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (writeHit) begin
            wrEn_q    <= 1'b1;
            wrAddr_q  <= {rowCur_q, colCnt_q[COL_W-1:0]};
            wrData_q  <= rgbAl;
            wrPlane_q <= planeCur_q;
          end
          if (overflowHit) begin
            err_q[ERR_OVERFLOW] <= 1'b1;
          end
          colCnt_q <= colCnt_d;
          if (latchRise) begin
            lineDone_q  <= 1'b1;
            lineLen_q   <= colCnt_d;
            if (colCnt_d != COLS_L) begin
              err_q[ERR_LENGTH] <= 1'b1;
            end
            rowCur_q    <= rowAl;
            planeCur_q  <= planeCur_d;
            frameDone_q <= (rowAl == LAST_ROW) && (planeCur_d == LAST_PLANE);
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (latchFall) begin
            state_q  <= ST_SHIFT;
            colCnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign wr_plane   = wrPlane_q;
  assign line_done  = lineDone_q;
  assign line_len   = lineLen_q;
  assign frame_done = frameDone_q;
  assign err        = err_q;

endmodule
